// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared encodings for the instruction fetch sequencer: FSM states and
// the instruction-word fields the sequencer has to look at.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        FETCH_IMM,
        WAIT_DONE,
        PAUSE,
        HALT
    } fetch_state_e;

    localparam logic [2:0] OP_MVI   = 3'b001;
    localparam int         HALT_BIT = 15;
    localparam int         OPC_HI   = 8;
    localparam int         OPC_LO   = 6;

    function automatic logic is_mvi(input logic [15:0] word);
        return word[OPC_HI:OPC_LO] == OP_MVI;
    endfunction

    function automatic logic is_halt(input logic [15:0] word);
        return word[HALT_BIT];
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Program-memory and core-side signals of the fetch sequencer.
// master = sequencer, slave = memory/core/host environment.
interface instr_fetch_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              Start;
    logic              StepMode;
    logic [ADDR_W-1:0] StartAddr;
    logic [ADDR_W-1:0] MemAddr;
    logic [15:0]       MemRdata;
    logic [15:0]       DIN;
    logic              Run;
    logic              Done;
    logic [ADDR_W-1:0] PC;
    logic [15:0]       InstrCount;
    logic              Busy;
    logic              Halted;
    logic              Fault;

    modport master (
        input  Start, StepMode, StartAddr, MemRdata, Done,
        output MemAddr, DIN, Run, PC, InstrCount, Busy, Halted, Fault
    );

    modport slave (
        output Start, StepMode, StartAddr, MemRdata, Done,
        input  MemAddr, DIN, Run, PC, InstrCount, Busy, Halted, Fault
    );
endinterface

// File: rtl/instr_fetch_sequencer_timer.sv
// Loadable down-counter that stops at zero; zero_o flags terminal count.
// Used for both the memory-latency wait and the Done watchdog.
module fetch_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetches instruction words from program memory, drives them to the core
// with a Run pulse, waits for Done, and advances the program counter.
//
// state     | meaning
// IDLE      | after reset, waiting for Start
// FETCH     | MemAddr = PC, waiting MEM_LATENCY cycles for the opcode word
// DECODE    | halt word -> HALT, else drive DIN
// ISSUE     | Run high for this one cycle
// FETCH_IMM | reading the mvi immediate from PC+1
// WAIT_DONE | waiting for Done (or a Done latched early)
// PAUSE     | single-step stop after an instruction, Start resumes
// HALT      | halt word or watchdog fault, Start relaunches
module instr_fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int MEM_LATENCY  = 1,
    parameter int DONE_TIMEOUT = 15
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    instr_fetch_sequencer_if.master bus
);
    // Timers stop at zero, so loading N-1 gives a wait of exactly N cycles.
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);
    localparam logic [7:0] WD_LOAD  = 8'(DONE_TIMEOUT - 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       instr_q;
    logic [15:0]       din_q;
    logic              run_q;
    logic [15:0]       instr_cnt_q;
    logic              busy_q;
    logic              halted_q;
    logic              fault_q;
    logic              done_seen_q;

    logic [ADDR_W-1:0] pc_plus1_d;
    logic [ADDR_W-1:0] pc_next_d;
    logic              cur_mvi;
    logic              done_any;
    logic              launch;
    logic              resume;
    logic              complete;
    logic              wd_expire;
    logic              lat_load;
    logic              lat_en;
    logic              lat_zero;
    logic              wd_load;
    logic              wd_en;
    logic              wd_zero;

    always_comb begin
        cur_mvi    = is_mvi(instr_q);
        pc_plus1_d = pc_q + ADDR_W'(1);
        pc_next_d  = cur_mvi ? pc_q + ADDR_W'(2) : pc_plus1_d;
        done_any   = bus.Done || done_seen_q;
        launch     = bus.Start && ((state_q == IDLE) || (state_q == HALT));
        resume     = bus.Start && (state_q == PAUSE);
        complete   = (state_q == WAIT_DONE) && done_any;
        wd_en      = (state_q == ISSUE) || (state_q == FETCH_IMM) || (state_q == WAIT_DONE);
        wd_expire  = wd_en && wd_zero && !done_any;
        wd_load    = (state_q == DECODE);
        lat_en     = (state_q == FETCH) || (state_q == FETCH_IMM);
        // Loads in ISSUE or on completion are harmless when the next state
        // does not use the latency timer.
        lat_load   = launch || resume || complete || (state_q == ISSUE);
    end

    fetch_wait_timer #(.W(3)) u_lat_timer (
        .clk_i      (Clock),
        .rst_i      (Resetn),
        .load_i     (lat_load),
        .load_val_i (LAT_LOAD),
        .en_i       (lat_en),
        .zero_o     (lat_zero)
    );

    fetch_wait_timer #(.W(8)) u_wd_timer (
        .clk_i      (Clock),
        .rst_i      (Resetn),
        .load_i     (wd_load),
        .load_val_i (WD_LOAD),
        .en_i       (wd_en),
        .zero_o     (wd_zero)
    );

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            mem_addr_q  <= '0;
            instr_q     <= '0;
            din_q       <= '0;
            run_q       <= 1'b0;
            instr_cnt_q <= '0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (launch) begin
                        pc_q        <= bus.StartAddr;
                        mem_addr_q  <= bus.StartAddr;
                        fault_q     <= 1'b0;
                        halted_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        done_seen_q <= 1'b0;
                        state_q     <= FETCH;
                    end
                end

                FETCH: begin
                    if (lat_zero) begin
                        instr_q <= bus.MemRdata;
                        state_q <= DECODE;
                    end
                end

                DECODE: begin
                    if (is_halt(instr_q)) begin
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        din_q   <= instr_q;
                        run_q   <= 1'b1;
                        state_q <= ISSUE;
                    end
                end

                ISSUE: begin
                    run_q <= 1'b0;
                    if (bus.Done) begin
                        done_seen_q <= 1'b1;
                    end
                    if (wd_expire) begin
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= HALT;
                    end else if (cur_mvi) begin
                        mem_addr_q <= pc_plus1_d;
                        state_q    <= FETCH_IMM;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end

                FETCH_IMM: begin
                    if (bus.Done) begin
                        done_seen_q <= 1'b1;
                    end
                    if (wd_expire) begin
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= HALT;
                    end else if (lat_zero) begin
                        din_q   <= bus.MemRdata;
                        state_q <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (complete) begin
                        pc_q        <= pc_next_d;
                        instr_cnt_q <= instr_cnt_q + 16'd1;
                        done_seen_q <= 1'b0;
                        if (bus.StepMode) begin
                            busy_q  <= 1'b0;
                            state_q <= PAUSE;
                        end else begin
                            mem_addr_q <= pc_next_d;
                            state_q    <= FETCH;
                        end
                    end else if (wd_expire) begin
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= HALT;
                    end
                end

                PAUSE: begin
                    if (resume) begin
                        mem_addr_q <= pc_q;
                        busy_q     <= 1'b1;
                        state_q    <= FETCH;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.MemAddr    = mem_addr_q;
    assign bus.DIN        = din_q;
    assign bus.Run        = run_q;
    assign bus.PC         = pc_q;
    assign bus.InstrCount = instr_cnt_q;
    assign bus.Busy       = busy_q;
    assign bus.Halted     = halted_q;
    assign bus.Fault      = fault_q;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a combinational program
// memory (one-cycle latency seen from the registered MemAddr).
module tb_instr_fetch_sequencer;
    logic        Clock  = 1'b0;
    logic        Resetn = 1'b1;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] mem [32];

    instr_fetch_sequencer_if #(.ADDR_W(5)) bus ();

    assign bus.MemRdata = mem[bus.MemAddr];

    instr_fetch_sequencer #(
        .ADDR_W       (5),
        .MEM_LATENCY  (1),
        .DONE_TIMEOUT (15)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        Resetn       = 1'b1;
        bus.Start    = 1'b0;
        bus.Done     = 1'b0;
        bus.StepMode = 1'b0;
        tick(2);
        Resetn = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] addr);
        bus.StartAddr = addr;
        bus.Start     = 1'b1;
        tick(1);
        bus.Start = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (bus.Run !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(bus.Run), 32'd1);
    endtask

    task automatic finish_instr;
        tick(1);
        bus.Done = 1'b1;
        tick(1);
        bus.Done = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_pc"},      32'(bus.PC),         32'd0);
        chk({pfx, "_memaddr"}, 32'(bus.MemAddr),    32'd0);
        chk({pfx, "_din"},     32'(bus.DIN),        32'd0);
        chk({pfx, "_run"},     32'(bus.Run),        32'd0);
        chk({pfx, "_cnt"},     32'(bus.InstrCount), 32'd0);
        chk({pfx, "_busy"},    32'(bus.Busy),       32'd0);
        chk({pfx, "_halted"},  32'(bus.Halted),     32'd0);
        chk({pfx, "_fault"},   32'(bus.Fault),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        bus.Start     = 1'b0;
        bus.StepMode  = 1'b0;
        bus.StartAddr = '0;
        bus.Done      = 1'b0;

        // Reset state
        tick(2);
        chk_reset_vals("rst");
        Resetn = 1'b0;

        // Plain mv then halt word
        mem[0] = 16'h0008;
        mem[1] = 16'h8000;
        pulse_start(5'd0);
        chk("t1_busy", 32'(bus.Busy), 32'd1);
        chk("t1_memaddr", 32'(bus.MemAddr), 32'd0);
        tick(2);
        chk("t1_run", 32'(bus.Run), 32'd1);
        chk("t1_din", 32'(bus.DIN), 32'h0008);
        tick(1);
        chk("t1_run_once", 32'(bus.Run), 32'd0);
        bus.Done = 1'b1;
        tick(1);
        bus.Done = 1'b0;
        chk("t1_pc", 32'(bus.PC), 32'd1);
        chk("t1_cnt", 32'(bus.InstrCount), 32'd1);
        tick(2);
        chk("t1_halted", 32'(bus.Halted), 32'd1);
        chk("t1_busy_off", 32'(bus.Busy), 32'd0);
        chk("t1_pc_halt", 32'(bus.PC), 32'd1);
        chk("t1_din_hold", 32'(bus.DIN), 32'h0008);

        // mvi with immediate
        do_reset();
        mem[3] = 16'h0040;
        mem[4] = 16'h1234;
        mem[5] = 16'h8000;
        pulse_start(5'd3);
        tick(2);
        chk("t2_run", 32'(bus.Run), 32'd1);
        chk("t2_din_op", 32'(bus.DIN), 32'h0040);
        tick(1);
        chk("t2_imm_addr", 32'(bus.MemAddr), 32'd4);
        chk("t2_din_hold", 32'(bus.DIN), 32'h0040);
        tick(1);
        chk("t2_din_imm", 32'(bus.DIN), 32'h1234);
        chk("t2_memaddr", 32'(bus.MemAddr), 32'd4);
        bus.Done = 1'b1;
        tick(1);
        bus.Done = 1'b0;
        chk("t2_pc", 32'(bus.PC), 32'd5);
        chk("t2_cnt", 32'(bus.InstrCount), 32'd1);
        tick(2);
        chk("t2_halted", 32'(bus.Halted), 32'd1);

        // Done coincident with the Run cycle is latched, not lost
        do_reset();
        mem[8] = 16'h0008;
        mem[9] = 16'h8000;
        pulse_start(5'd8);
        tick(2);
        chk("t3_run", 32'(bus.Run), 32'd1);
        bus.Done = 1'b1;
        tick(1);
        bus.Done = 1'b0;
        chk("t3_pc_pending", 32'(bus.PC), 32'd8);
        tick(1);
        chk("t3_pc", 32'(bus.PC), 32'd9);
        chk("t3_cnt", 32'(bus.InstrCount), 32'd1);
        chk("t3_fault", 32'(bus.Fault), 32'd0);
        tick(2);
        chk("t3_halted", 32'(bus.Halted), 32'd1);

        // Watchdog: no Done, Start ignored while busy
        do_reset();
        mem[10] = 16'h0008;
        mem[11] = 16'h8000;
        pulse_start(5'd10);
        tick(2);
        chk("t4_run", 32'(bus.Run), 32'd1);
        tick(1);
        pulse_start(5'd11);
        tick(12);
        chk("t4_fault_early", 32'(bus.Fault), 32'd0);
        chk("t4_halted_early", 32'(bus.Halted), 32'd0);
        tick(1);
        chk("t4_fault", 32'(bus.Fault), 32'd1);
        chk("t4_halted", 32'(bus.Halted), 32'd1);
        chk("t4_pc", 32'(bus.PC), 32'd10);
        chk("t4_cnt", 32'(bus.InstrCount), 32'd0);
        chk("t4_busy", 32'(bus.Busy), 32'd0);
        bus.Done = 1'b1;
        tick(1);
        bus.Done = 1'b0;
        chk("t4_done_ignored", 32'(bus.InstrCount), 32'd0);
        pulse_start(5'd11);
        chk("t4_fault_clr", 32'(bus.Fault), 32'd0);
        chk("t4_pc_launch", 32'(bus.PC), 32'd11);
        chk("t4_halted_clr", 32'(bus.Halted), 32'd0);
        tick(2);
        chk("t4_halt_again", 32'(bus.Halted), 32'd1);

        // Single-step through three instructions
        do_reset();
        mem[12] = 16'h0008;
        mem[13] = 16'h0010;
        mem[14] = 16'h0018;
        mem[15] = 16'h8000;
        bus.StepMode = 1'b1;
        pulse_start(5'd12);
        for (int k = 1; k <= 3; k++) begin
            wait_run($sformatf("t5_run_%0d", k));
            finish_instr();
            chk($sformatf("t5_cnt_%0d", k), 32'(bus.InstrCount), 32'(k));
            chk($sformatf("t5_pc_%0d", k), 32'(bus.PC), 32'(12 + k));
            tick(3);
            chk($sformatf("t5_busy_pause_%0d", k), 32'(bus.Busy), 32'd0);
            chk($sformatf("t5_nofetch_%0d", k), 32'(bus.MemAddr), 32'(11 + k));
            pulse_start(5'd0);
            chk($sformatf("t5_resume_addr_%0d", k), 32'(bus.MemAddr), 32'(12 + k));
            chk($sformatf("t5_resume_busy_%0d", k), 32'(bus.Busy), 32'd1);
        end
        tick(2);
        chk("t5_halted", 32'(bus.Halted), 32'd1);
        chk("t5_cnt_final", 32'(bus.InstrCount), 32'd3);

        // mvi at the top address wraps, then reset mid-WAIT_DONE
        do_reset();
        mem[31] = 16'h0040;
        mem[0]  = 16'h00AB;
        mem[1]  = 16'h8000;
        mem[2]  = 16'h0008;
        pulse_start(5'd31);
        chk("t6_memaddr", 32'(bus.MemAddr), 32'd31);
        tick(2);
        chk("t6_run", 32'(bus.Run), 32'd1);
        tick(1);
        chk("t6_imm_addr_wrap", 32'(bus.MemAddr), 32'd0);
        tick(1);
        chk("t6_din_imm", 32'(bus.DIN), 32'h00AB);
        bus.Done = 1'b1;
        tick(1);
        bus.Done = 1'b0;
        chk("t6_pc_wrap", 32'(bus.PC), 32'd1);
        chk("t6_cnt", 32'(bus.InstrCount), 32'd1);
        tick(2);
        chk("t6_halted", 32'(bus.Halted), 32'd1);
        pulse_start(5'd2);
        tick(3);
        chk("t6_busy_wait", 32'(bus.Busy), 32'd1);
        chk("t6_din_wait", 32'(bus.DIN), 32'h0008);
        Resetn = 1'b1;
        tick(1);
        chk_reset_vals("t6_rst");
        Resetn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
